cordic_controller: RTL

CORDIC_CONTROLLER -- requirements
Module: cordic_controller

---
 rtl/cordic_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cordic_controller.sv
// Sequencer for an external CORDIC iteration core: accepts a command, steps the core for
// in_iters_i cycles, then presents the result. Optional macro CORDIC_CTRL_OVF_ABORT_EN ends a run early on core overflow.
module cordic_controller #(
   parameter int P_WIDTH     = 32,
   parameter int P_ITER_BITS = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,

   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [P_WIDTH-1:0]     in_x_i,
   input  logic [P_WIDTH-1:0]     in_y_i,
   input  logic [P_WIDTH-1:0]     in_z_i,
   input  logic                   in_system_i,
   input  logic                   in_mode_i,
   input  logic [P_ITER_BITS-1:0] in_iters_i,

   output logic [P_WIDTH-1:0]     core_x_o,
   output logic [P_WIDTH-1:0]     core_y_o,
   output logic [P_WIDTH-1:0]     core_z_o,
   output logic [P_ITER_BITS-1:0] core_iter_o,
   output logic                   core_system_o,
   output logic                   core_mode_o,
   input  logic [P_WIDTH-1:0]     core_x_i,
   input  logic [P_WIDTH-1:0]     core_y_i,
   input  logic [P_WIDTH-1:0]     core_z_i,
   input  logic                   core_ovf_i,

   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [P_WIDTH-1:0]     out_x_o,
   output logic [P_WIDTH-1:0]     out_y_o,
   output logic [P_WIDTH-1:0]     out_z_o,
   output logic                   out_ovf_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [P_ITER_BITS-1:0] IDX_MAX = '1;
   localparam logic [P_ITER_BITS-1:0] ONE     = P_ITER_BITS'(1);

   state_t                 state;
   state_t                 state_next;
   logic [P_WIDTH-1:0]     x_q;
   logic [P_WIDTH-1:0]     y_q;
   logic [P_WIDTH-1:0]     z_q;
   logic [P_ITER_BITS-1:0] remaining;
   logic [P_ITER_BITS-1:0] iter_idx;
   logic                   rep_done;
   logic                   system_q;
   logic                   mode_q;
   logic                   ovf_q;
   logic                   is_rep_idx;
   logic                   last_cycle;

   // Hyperbolic convergence needs indices 4 and 13 applied twice.
   assign is_rep_idx = (32'(iter_idx) == 32'd4) || (32'(iter_idx) == 32'd13);

`ifdef CORDIC_CTRL_OVF_ABORT_EN
   assign last_cycle = (remaining == ONE) || core_ovf_i;
`else
   assign last_cycle = (remaining == ONE);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid_i) begin
               state_next = (in_iters_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_cycle) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
         remaining <= '0;
         iter_idx  <= '0;
         rep_done  <= 1'b0;
         system_q  <= 1'b0;
         mode_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid_i) begin
                  x_q       <= in_x_i;
                  y_q       <= in_y_i;
                  z_q       <= in_z_i;
                  system_q  <= in_system_i;
                  mode_q    <= in_mode_i;
                  remaining <= in_iters_i;
                  iter_idx  <= in_system_i ? '0 : ONE;
                  rep_done  <= 1'b0;
                  ovf_q     <= 1'b0;
               end
            end
            RUN: begin
               x_q       <= core_x_i;
               y_q       <= core_y_i;
               z_q       <= core_z_i;
               remaining <= remaining - ONE;
               ovf_q     <= ovf_q | core_ovf_i;
               if (!system_q && is_rep_idx && !rep_done) begin
                  rep_done <= 1'b1;
               end else begin
                  rep_done <= 1'b0;
                  if (iter_idx != IDX_MAX) begin
                     iter_idx <= iter_idx + ONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready_o    = (state == IDLE);
   assign out_valid_o   = (state == DONE);
   assign core_x_o      = x_q;
   assign core_y_o      = y_q;
   assign core_z_o      = z_q;
   assign core_iter_o   = iter_idx;
   assign core_system_o = system_q;
   assign core_mode_o   = mode_q;
   assign out_x_o       = x_q;
   assign out_y_o       = y_q;
   assign out_z_o       = z_q;
   assign out_ovf_o     = ovf_q;

endmodule
